// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master Wishbone arbiter, round-robin on ties, grant held per transaction.
// Optional bus-timeout termination enabled by defining WB_ARB_TIMEOUT_EN.
`default_nettype none

module wb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OWN_M0 = 2'd1;
    localparam logic [1:0] ST_OWN_M1 = 2'd2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_check
        $error("wb_master_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_owner;     // 1 = debug master owned the bus last
    logic       req0;
    logic       req1;
    logic       own_cyc;
    logic       own_stb;
    logic       timeout_hit;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tcount;

    // Ack/err in the expiry cycle takes precedence over the timeout.
    assign timeout_hit = (state != ST_IDLE) && (tcount == CNT_W'(TIMEOUT_CYCLES))
                         && !wb_ack_i && !wb_err_i;

    // The owned phase always ends by the cycle tcount reaches TIMEOUT_CYCLES, so no wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcount <= '0;
        end else if (state == ST_IDLE) begin
            tcount <= '0;
        end else begin
            tcount <= tcount + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        wb_adr_o = 32'd0;
        wb_dat_o = 32'd0;
        wb_sel_o = 4'd0;
        wb_we_o  = 1'b0;
        case (state)
            ST_OWN_M0: begin
                own_cyc  = m0_cyc_i;
                own_stb  = m0_stb_i;
                wb_adr_o = m0_adr_i;
                wb_dat_o = m0_dat_i;
                wb_sel_o = m0_sel_i;
                wb_we_o  = m0_we_i;
            end
            ST_OWN_M1: begin
                own_cyc  = m1_cyc_i;
                own_stb  = m1_stb_i;
                wb_adr_o = m1_adr_i;
                wb_dat_o = m1_dat_i;
                wb_sel_o = m1_sel_i;
                wb_we_o  = m1_we_i;
            end
            default: begin
            end
        endcase
        wb_cyc_o = own_cyc & own_stb & ~timeout_hit;
        wb_stb_o = own_cyc & own_stb & ~timeout_hit;
    end

    assign m0_dat_o  = wb_dat_i;
    assign m1_dat_o  = wb_dat_i;
    assign m0_ack_o  = (state == ST_OWN_M0) & wb_ack_i;
    assign m0_err_o  = (state == ST_OWN_M0) & (wb_err_i | timeout_hit);
    assign m1_ack_o  = (state == ST_OWN_M1) & wb_ack_i;
    assign m1_err_o  = (state == ST_OWN_M1) & (wb_err_i | timeout_hit);
    assign grant_o   = {state == ST_OWN_M1, state == ST_OWN_M0};
    assign timeout_o = timeout_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req0 && (!req1 || last_owner)) begin
                    state_nxt = ST_OWN_M0;
                end else if (req1) begin
                    state_nxt = ST_OWN_M1;
                end
            end
            ST_OWN_M0, ST_OWN_M1: begin
                if (wb_ack_i || wb_err_i || !own_cyc || timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt != ST_IDLE) begin
                last_owner <= (state_nxt == ST_OWN_M1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
// Randomized scoreboard bench for wb_master_arbiter against a transaction-level owner model.
`timescale 1ns/1ps
`default_nettype none

module tb_wb_master_arbiter;

    localparam int TO = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_adr = 0, m0_dat = 0;
    logic [3:0]  m0_sel = 0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_adr = 0, m1_dat = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] wb_dat_i = 0;
    logic        wb_ack_i = 0, wb_err_i = 0;

    logic [31:0] m0_dat_o, m1_dat_o, wb_adr_o, wb_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, timeout_o;
    logic [1:0]  grant_o;

    always #5 clk = ~clk;

    wb_master_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we, cyc, stb;
        logic [31:0] m0_dat, m1_dat;
        logic        m0_ack, m0_err, m1_ack, m1_err, timeout;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: who owns the bus, who won last, how long the owner has held it.
    int owner    = 0;       // 0 none, 1 core, 2 debug
    bit last_dbg = 1'b1;
    int age      = 0;
    bit done0, done1;
    bit busy0 = 0, busy1 = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expectation for the current cycle and compares every output.
    exp_t m;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m = sb.pop_front();
            chk("grant_o",   32'(grant_o),   32'(m.grant));
            chk("wb_adr_o",  wb_adr_o,       m.adr);
            chk("wb_dat_o",  wb_dat_o,       m.dat);
            chk("wb_sel_o",  32'(wb_sel_o),  32'(m.sel));
            chk("wb_we_o",   32'(wb_we_o),   32'(m.we));
            chk("wb_cyc_o",  32'(wb_cyc_o),  32'(m.cyc));
            chk("wb_stb_o",  32'(wb_stb_o),  32'(m.stb));
            chk("m0_dat_o",  m0_dat_o,       m.m0_dat);
            chk("m1_dat_o",  m1_dat_o,       m.m1_dat);
            chk("m0_ack_o",  32'(m0_ack_o),  32'(m.m0_ack));
            chk("m0_err_o",  32'(m0_err_o),  32'(m.m0_err));
            chk("m1_ack_o",  32'(m1_ack_o),  32'(m.m1_ack));
            chk("m1_err_o",  32'(m1_err_o),  32'(m.m1_err));
            chk("timeout_o", 32'(timeout_o), 32'(m.timeout));
        end
    end

    // Predict this cycle's outputs from the current inputs, advance the model, clock once.
    task automatic step();
        exp_t e;
        bit   r0, r1, cyc, stb, to, fin;
        e = '{default: 0};
        r0 = m0_cyc && m0_stb;
        r1 = m1_cyc && m1_stb;
        e.m0_dat = wb_dat_i;
        e.m1_dat = wb_dat_i;
        done0 = 0;
        done1 = 0;
        fin   = 0;
        if (owner != 0) begin
            if (owner == 1) begin
                e.grant = 2'b01; e.adr = m0_adr; e.dat = m0_dat; e.sel = m0_sel; e.we = m0_we;
                cyc = m0_cyc; stb = m0_stb;
            end else begin
                e.grant = 2'b10; e.adr = m1_adr; e.dat = m1_dat; e.sel = m1_sel; e.we = m1_we;
                cyc = m1_cyc; stb = m1_stb;
            end
            to = TO_EN && (age == TO) && !wb_ack_i && !wb_err_i;
            e.cyc     = cyc && stb && !to;
            e.stb     = e.cyc;
            e.timeout = to;
            if (owner == 1) begin
                e.m0_ack = wb_ack_i;
                e.m0_err = wb_err_i || to;
                done0    = wb_ack_i || wb_err_i || to;
            end else begin
                e.m1_ack = wb_ack_i;
                e.m1_err = wb_err_i || to;
                done1    = wb_ack_i || wb_err_i || to;
            end
            fin = wb_ack_i || wb_err_i || to || !cyc;
        end
        sb.push_back(e);
        if (rst) begin
            owner = 0; last_dbg = 1; age = 0;
        end else if (owner == 0) begin
            if (r0 && r1) owner = last_dbg ? 2'd1 : 2'd2;
            else if (r0)  owner = 1;
            else if (r1)  owner = 2;
            if (owner != 0) begin
                last_dbg = (owner == 2);
                age = 0;
            end
        end else if (fin) begin
            owner = 0;
        end else begin
            age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        int r;
        rst = ($urandom_range(99) < 2);
        if (!busy0) begin
            m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
            busy0  = ($urandom_range(99) < 30);
            m0_cyc = busy0; m0_stb = busy0;
        end else if ($urandom_range(99) < 4) begin
            busy0 = 0; m0_cyc = 0; m0_stb = 0;
        end
        if (!busy1) begin
            m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
            busy1  = ($urandom_range(99) < 30);
            m1_cyc = busy1; m1_stb = busy1;
        end else if ($urandom_range(99) < 4) begin
            busy1 = 0; m1_cyc = 0; m1_stb = 0;
        end
        wb_dat_i = $urandom;
        r = $urandom_range(99);
        wb_ack_i = 0;
        wb_err_i = 0;
        if (owner != 0) begin
            if (r < 30)      wb_ack_i = 1;
            else if (r < 38) wb_err_i = 1;
            else if (r < 42) begin wb_ack_i = 1; wb_err_i = 1; end
        end else if (r < 5) begin
            wb_ack_i = 1;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        step();
        rst = 0;

        // Tie from reset, slave acks two cycles after each grant, requests continuous.
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h2000_0004; m0_dat = 0;            m0_sel = 4'hF;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_0100; m1_dat = 32'h1234_5678; m1_sel = 4'hF;
        for (int k = 0; k < 16; k++) begin
            wb_dat_i = 32'hDEAD_BEEF;
            wb_ack_i = (owner != 0) && (age == 2);
            wb_err_i = 0;
            step();
        end

        // Slave error on core accesses.
        m1_cyc = 0; m1_stb = 0;
        for (int k = 0; k < 6; k++) begin
            wb_ack_i = 0;
            wb_err_i = (owner == 1) && (age == 1);
            step();
        end

        // Reset while debug owns the bus, then a late ack and a fresh tie.
        m0_cyc = 0; m0_stb = 0; wb_err_i = 0; wb_ack_i = 0;
        m1_cyc = 1; m1_stb = 1;
        for (int k = 0; k < 3; k++) step();
        rst = 1;
        step();
        rst = 0; wb_ack_i = 1; m0_cyc = 1; m0_stb = 1;
        step();
        wb_ack_i = 0;
        for (int k = 0; k < 3; k++) step();

        // Randomized traffic.
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        busy0 = 0; busy1 = 0;
        for (int k = 0; k < 3000; k++) begin
            drive_random();
            step();
            if (done0 || rst) begin busy0 = 0; end
            if (done1 || rst) begin busy1 = 0; end
            if (!busy0) begin m0_cyc = 0; m0_stb = 0; end
            if (!busy1) begin m1_cyc = 0; m1_stb = 0; end
        end
        rst = 0;

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
